// File: rtl/lfsr_scrambler_pkg.sv
// Shared constants and FSM state type for the LFSR payload scrambler.
// Build option: LFSR_ADDR_CHECK_EN adds the addr_err output on the top.
package lfsr_scrambler_pkg;

  localparam int          DEF_LFSR_W    = 16;
  localparam logic [15:0] DEF_TAPS      = 16'h002D;
  localparam logic [15:0] DEF_SEED      = 16'hACE1;
  localparam int          DEF_ADDR_W    = 14;
  localparam int          DEF_FRAME_LEN = 12282;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/lfsr_scrambler_lfsr_core.sv
// Fibonacci LFSR keystream source: SEED load, right shift, lock-up guard.
// Ports: clk, rst, load_i, adv_i -> state_o (register), ks_o (bit 0).
module lfsr_core
  import lfsr_scrambler_pkg::*;
#(
  parameter int             W    = DEF_LFSR_W,
  parameter logic [W-1:0]   TAPS = DEF_TAPS,
  parameter logic [W-1:0]   SEED = DEF_SEED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         adv_i,
  output logic [W-1:0] state_o,
  output logic         ks_o
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic         fb;

  // An all-zero register can never leave zero by
  // shifting, so it is treated like a load request.
  always_comb begin
    fb     = ^(lfsr_q & TAPS);
    lfsr_d = lfsr_q;
    if (load_i || (lfsr_q == '0))
      lfsr_d = SEED;
    else if (adv_i)
      lfsr_d = {fb, lfsr_q[W-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr_q <= SEED;
    else
      lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;
  assign ks_o    = lfsr_q[0];

endmodule

// File: rtl/lfsr_scrambler.sv
// Frame scrambler: XORs payload bits with an LFSR keystream and counts
// bits to the frame length. Ports: clk, rst, st, in_valid/in_bit/in_addr
// in; out_valid/out_bit/out_addr, frame_done, busy, lfsr_state out.
// LFSR_ADDR_CHECK_EN adds sticky addr_err (in_addr must be count+1).
module lfsr_scrambler
  import lfsr_scrambler_pkg::*;
#(
  parameter int                LFSR_W    = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS      = DEF_TAPS,
  parameter logic [LFSR_W-1:0] SEED      = DEF_SEED,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic              out_bit,
  output logic [ADDR_W-1:0] out_addr,
  output logic              frame_done,
  output logic              busy,
  output logic [LFSR_W-1:0] lfsr_state
`ifdef LFSR_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE  =
    ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] count_q;
  logic              out_valid_q;
  logic              out_bit_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              frame_done_q;
  logic              busy_q;
  logic              ks;
  logic              load;
  logic              adv;
`ifdef LFSR_ADDR_CHECK_EN
  logic              addr_err_q;
`endif

  // IDLE keeps the keystream parked at SEED; an abort
  // reloads it on the same edge that returns to IDLE.
  assign load = (state_q == IDLE) ||
                ((state_q == RUN) && !st);
  assign adv  = (state_q == RUN) && st && in_valid;

  lfsr_core #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .adv_i   (adv),
    .state_o (lfsr_state),
    .ks_o    (ks)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_addr_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LFSR_ADDR_CHECK_EN
      addr_err_q   <= 1'b0;
`endif
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          count_q <= '0;
`ifdef LFSR_ADDR_CHECK_EN
          addr_err_q <= 1'b0;
`endif
          if (st) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!st) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
`ifdef LFSR_ADDR_CHECK_EN
            addr_err_q <= 1'b0;
`endif
          end else if (in_valid) begin
            out_valid_q <= 1'b1;
            out_bit_q   <= in_bit ^ ks;
            out_addr_q  <= in_addr;
            count_q     <= count_q + ONE;
`ifdef LFSR_ADDR_CHECK_EN
            // Counter's first address after st is 1.
            if (in_addr != count_q + ONE)
              addr_err_q <= 1'b1;
`endif
            if (count_q == LAST) begin
              frame_done_q <= 1'b1;
              state_q      <= DONE;
              busy_q       <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!st) begin
            state_q <= IDLE;
`ifdef LFSR_ADDR_CHECK_EN
            addr_err_q <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_addr   = out_addr_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
`ifdef LFSR_ADDR_CHECK_EN
  assign addr_err   = addr_err_q;
`endif

endmodule

// File: tb/tb_lfsr_scrambler.sv
// Self-checking bench for lfsr_scrambler against a keystream table.
// Covers reset, first bits, full/gapped frames, abort, async rst.
module tb_lfsr_scrambler;
  import lfsr_scrambler_pkg::*;

  localparam int N = DEF_FRAME_LEN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic [13:0] in_addr = '0;
  logic        out_valid;
  logic        out_bit;
  logic [13:0] out_addr;
  logic        frame_done;
  logic        busy;
  logic [15:0] lfsr_state;
`ifdef LFSR_ADDR_CHECK_EN
  logic        addr_err;
`endif

  lfsr_scrambler dut (
    .clk        (clk),
    .rst        (rst),
    .st         (st),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .out_addr   (out_addr),
    .frame_done (frame_done),
    .busy       (busy),
    .lfsr_state (lfsr_state)
`ifdef LFSR_ADDR_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ref_l[k] = keystream register before the k-th accepted bit
  logic [15:0] ref_l [0:N];
  bit          pay   [0:N-1];
  bit          out_a [0:N-1];
  bit          out_b [0:N-1];
  int          bad, pulses, dones, done_addr, extra;

  logic [15:0] t1_l [3] = '{16'h5670, 16'hAB38, 16'h559C};
  bit          t1_o [3] = '{1'b0, 1'b1, 1'b1};
  bit          t4_o [3] = '{1'b1, 1'b0, 1'b0};

  // Next register: halve, and put the tap parity on top.
  function automatic logic [15:0] nxt(input logic [15:0] s);
    int ones;
    ones = $countones(s & 16'h002D);
    return 16'((s >> 1) + ((ones % 2 == 1) ? 16'h8000 : 16'h0));
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    assert (o === e)
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bad = 0; pulses = 0; dones = 0;
    done_addr = -1; extra = 0;
  endtask

  task automatic acc(input int k, input bit b, input int sel);
    in_valid = 1'b1;
    in_bit   = b;
    in_addr  = 14'(k + 1);
    step();
    if (out_valid !== 1'b1 ||
        out_bit !== (b ^ ref_l[k][0]) ||
        out_addr !== 14'(k + 1) ||
        lfsr_state !== ref_l[k+1])
      bad++;
    if (out_valid === 1'b1) pulses++;
    if (frame_done === 1'b1) begin
      dones++;
      done_addr = int'(out_addr);
    end
    if (sel == 0) out_a[k] = out_bit;
    else out_b[k] = out_bit;
  endtask

  task automatic gap(input int k);
    in_valid = 1'b0;
    in_bit   = 1'($urandom);
    in_addr  = 14'($urandom);
    step();
    if (out_valid !== 1'b0 || frame_done !== 1'b0 ||
        lfsr_state !== ref_l[k])
      bad++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int diff;
    ref_l[0] = 16'hACE1;
    for (int k = 0; k < N; k++) begin
      ref_l[k+1] = nxt(ref_l[k]);
      pay[k]     = 1'($urandom);
    end

    // reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_bit", out_bit, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr", lfsr_state, 16'hACE1);

    // first three bits, in_bit=1
    st = 1'b1;
    step();
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      in_addr  = 14'(i + 1);
      step();
      chk("t1_valid", out_valid, 1);
      chk("t1_bit", out_bit, t1_o[i]);
      chk("t1_lfsr", lfsr_state, t1_l[i]);
    end
    st = 1'b0;
    in_valid = 1'b0;
    step();
    chk("t1_abort_busy", busy, 0);
    chk("t1_abort_lfsr", lfsr_state, 16'hACE1);
    chk("t1_abort_valid", out_valid, 0);

    // full continuous frame
    st = 1'b1;
    step();
    clr();
    for (int k = 0; k < N; k++) acc(k, pay[k], 0);
    chk("full_bad", bad, 0);
    chk("full_pulses", pulses, N);
    chk("full_dones", dones, 1);
    chk("full_done_addr", done_addr, N);
    chk("full_busy_after", busy, 0);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      step();
      if (out_valid !== 1'b0 || frame_done !== 1'b0) extra++;
    end
    chk("done_no_output", extra, 0);
    chk("done_lfsr_hold", lfsr_state, ref_l[N]);
    st = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    chk("idle_lfsr_seed", lfsr_state, 16'hACE1);

    // gapped frame, same payload
    st = 1'b1;
    step();
    clr();
    for (int k = 0; k < N; k++) begin
      gap(k);
      acc(k, pay[k], 1);
    end
    chk("gap_bad", bad, 0);
    chk("gap_pulses", pulses, N);
    chk("gap_done_addr", done_addr, N);
    diff = 0;
    for (int k = 0; k < N; k++)
      if (out_a[k] != out_b[k]) diff++;
    chk("gap_stream_equal", diff, 0);
    st = 1'b0;
    in_valid = 1'b0;
    step();
    step();

    // abort at bit 500, then restart
    st = 1'b1;
    step();
    clr();
    for (int k = 0; k < 500; k++) acc(k, 1'($urandom), 0);
    st = 1'b0;
    in_valid = 1'b0;
    step();
    chk("abort_bad", bad, 0);
    chk("abort_no_done", dones, 0);
    chk("abort_lfsr", lfsr_state, 16'hACE1);
    chk("abort_busy", busy, 0);
    st = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b0;
      in_addr  = 14'(i + 1);
      step();
      chk("restart_bit", out_bit, t4_o[i]);
      chk("restart_lfsr", lfsr_state, t1_l[i]);
    end

    // async reset between edges
    clr();
    for (int k = 3; k < 13; k++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      in_addr  = 14'(k + 1);
      step();
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_addr", out_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_lfsr", lfsr_state, 16'hACE1);
    st = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

`ifdef LFSR_ADDR_CHECK_EN
    st = 1'b1;
    step();
    for (int k = 0; k < 7; k++) acc(k, 1'b0, 0);
    chk("aerr_clean", addr_err, 0);
    in_valid = 1'b1;
    in_addr  = 14'd9;
    step();
    chk("aerr_set", addr_err, 1);
    in_valid = 1'b0;
    step();
    chk("aerr_sticky", addr_err, 1);
    st = 1'b0;
    step();
    chk("aerr_clear", addr_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_scrambler.md
Name: lfsr_scrambler

Overview:
Downstream consumer of the frame address counter. Accepts the serial payload bit read at each counter address and XORs it with a 16-bit Fibonacci LFSR keystream. Tracks the accepted-bit count against the frame length and raises frame_done at the end of the frame. Sits between the payload ROM / address counter and the serial output stage.

Parameters:
LFSR_W, 16, LFSR width in bits.
TAPS, 16'h002D, feedback mask; feedback = XOR of the lfsr bits whose mask bit is set (default uses bits 0, 2, 3, 5).
SEED, 16'hACE1, non-zero LFSR load value.
ADDR_W, 14, address/count width.
FRAME_LEN, 12282, payload bits per frame; must be ≤ 2^ADDR_W − 1.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
st  in  1  frame enable; same signal that drives the address counter
in_valid  in  1  in_bit/in_addr valid this cycle
in_bit  in  1  payload bit
in_addr  in  ADDR_W  counter address of in_bit
out_valid  out  1  out_bit valid
out_bit  out  1  scrambled bit
out_addr  out  ADDR_W  address accompanying out_bit
frame_done  out  1  one-cycle pulse on the final bit of the frame
busy  out  1  high in RUN
lfsr_state  out  LFSR_W  current LFSR register (debug)

Behaviour:
- Reset values (asynchronous): state=IDLE, lfsr=SEED, count=0, out_valid=0, out_bit=0, out_addr=0, frame_done=0, busy=0.
- State IDLE:
  - lfsr held at SEED, count=0, in_valid ignored.
  - st=1 → RUN on the next edge.
- State RUN:
  - busy=1.
  - On each in_valid=1 cycle:
    - out_bit <= in_bit ^ lfsr[0]; out_addr <= in_addr; out_valid <= 1 (latency 1 cycle).
    - lfsr <= {fb, lfsr[LFSR_W-1:1]}, where fb = ^(lfsr & TAPS).
    - count <= count+1.
  - in_valid=0 → out_valid <= 0; lfsr and count hold.
  - Accepted bit with count == FRAME_LEN−1 → frame_done <= 1 for one cycle (coincident with that bit's out_valid); next state DONE.
  - st falls mid-frame → abort: IDLE next edge, lfsr reloads SEED, count clears, no frame_done.
- State DONE:
  - busy=0, in_valid ignored, out_valid=0.
  - Remain until st=0, then IDLE. A new frame therefore requires st to drop and rise again.
- Lock-up guard: if lfsr==0 (illegal SEED or upset), reload SEED on the next edge instead of shifting.
- Width rules:
  - count is ADDR_W bits and never wraps, because DONE is entered first.
  - out_addr is a straight register copy of in_addr, with no arithmetic.
- rst mid-frame: immediate return to reset values regardless of state.

Optional Feature:
LFSR_ADDR_CHECK_EN
- Defined:
  - Adds output addr_err (1 bit, reset 0).
  - In RUN, on each accepted bit, in_addr must equal count+1, because the counter's first address after st rises is 1.
  - A mismatch sets addr_err sticky until IDLE or rst.
- Undefined: port absent; in_addr is passed through unchecked.

Decomposition:
- Shared package: LFSR_W, TAPS, SEED, FRAME_LEN, ADDR_W defaults, and the state enum (IDLE, RUN, DONE).
- One natural sub-module, lfsr_core: holds SEED load, advance, and the zero guard; exposes state and the keystream bit. The FSM, count, and output registers stay in lfsr_scrambler.

Test Plan:
- Reset then st=1, in_valid=1, in_bit=1 for 3 cycles → out_bit 0,1,1; lfsr_state 0xACE1→0x5670→0xAB38→0x559C.
- Full frame with continuous valid → exactly 12282 out_valid pulses; frame_done high on the pulse where out_addr=12282; busy low afterward; no further output while st=1.
- in_valid gapped every other cycle → lfsr and count freeze on idle cycles; output stream is identical to the continuous case.
- st dropped at bit 500, then raised again → no frame_done; second frame restarts keystream at 1,0,0 from SEED 0xACE1.
- rst asserted mid-frame between clock edges → outputs clear asynchronously; lfsr_state=0xACE1.
- With LFSR_ADDR_CHECK_EN, feed in_addr skipping from 7 to 9 → addr_err rises with that bit and stays high; clears on return to IDLE.
